reset_recovery_ctrl: RTL and testbench

Controller that sequences the negative-edge detector in the reset-recovery path. It gates the detector's `enable` and, on each detected fault edge, issues a timed downstream reset pulse. It then enforces a hold-off window and waits for the downstream logic to report ready. Failed recoveries are retried a bounded number of times before the block latches a sticky failure.

---
 rtl/reset_recovery_ctrl_if.sv | 39 +++
 rtl/reset_recovery_ctrl.sv | 157 +++++++++++++++
 tb/tb_reset_recovery_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/reset_recovery_ctrl_if.sv
// Signal bundle between the reset-recovery controller and its surroundings:
// the edge detector, the downstream reset domain and status observers.
interface reset_recovery_ctrl_if #(
    parameter int CNT_WIDTH = 8,
    parameter int RETRY_W   = 2
);
    logic                 detected;
    logic                 ready;
    logic                 enable;
    logic                 sys_reset;
    logic                 busy;
    logic                 fail;
    logic [CNT_WIDTH-1:0] recovery_count;
    logic [RETRY_W-1:0]   retry_count;

    // Controller side
    modport master (
        input  detected,
        input  ready,
        output enable,
        output sys_reset,
        output busy,
        output fail,
        output recovery_count,
        output retry_count
    );

    // Detector / downstream / observer side
    modport slave (
        output detected,
        output ready,
        input  enable,
        input  sys_reset,
        input  busy,
        input  fail,
        input  recovery_count,
        input  retry_count
    );
endinterface

// File: rtl/reset_recovery_ctrl.sv
// Reset-recovery sequencer: arms the negative-edge detector after reset,
// issues a timed downstream reset per accepted fault edge, waits out a
// hold-off window, then waits for ready with bounded retries before a
// sticky failure. All outputs are registered from the next-state decode.
module reset_recovery_ctrl #(
    parameter int ARM_CYCLES     = 4,
    parameter int RESET_CYCLES   = 8,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    reset_recovery_ctrl_if.master bus
);

    // One timer serves every state, so it must hold the largest interval.
    localparam int MAX_AR  = (ARM_CYCLES > RESET_CYCLES) ? ARM_CYCLES : RESET_CYCLES;
    localparam int MAX_HT  = (HOLDOFF_CYCLES > TIMEOUT_CYCLES) ? HOLDOFF_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_P   = (MAX_AR > MAX_HT) ? MAX_AR : MAX_HT;
    localparam int TW      = $clog2(MAX_P + 1);
    localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]        ARM_LAST  = TW'(ARM_CYCLES - 1);
    localparam logic [TW-1:0]        RESET_LD  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0]        HOLD_LD   = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [TW-1:0]        TOUT_LD   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]        T_ONE     = TW'(1);
    localparam logic [RW-1:0]        RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [RW-1:0]        R_ONE     = RW'(1);
    localparam logic [CNT_WIDTH-1:0] C_ONE     = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ASSERT,
        ST_HOLDOFF,
        ST_WAIT_READY,
        ST_FAIL
    } state_t;

    state_t                state, state_nx;
    logic [TW-1:0]         timer, timer_nx;
    logic [CNT_WIDTH-1:0]  rec_cnt, rec_cnt_nx;
    logic [RW-1:0]         retry_cnt, retry_cnt_nx;
    logic                  enable_q, sys_reset_q, busy_q, fail_q;
    logic                  enable_nx, sys_reset_nx, busy_nx, fail_nx;

    // Next-state, timer, counter and output decode for the recovery sequence
    always_comb begin
        state_nx     = state;
        timer_nx     = timer;
        rec_cnt_nx   = rec_cnt;
        retry_cnt_nx = retry_cnt;

        case (state)
            ST_IDLE: begin
                // Counts up from the reset value of zero until arming.
                if (timer == ARM_LAST) begin
                    state_nx = ST_ARMED;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + T_ONE;
                end
            end
            ST_ARMED: begin
                if (bus.detected) begin
                    state_nx     = ST_ASSERT;
                    timer_nx     = RESET_LD;
                    retry_cnt_nx = '0;
                    if (rec_cnt != '1) begin
                        rec_cnt_nx = rec_cnt + C_ONE;
                    end
                end
            end
            ST_ASSERT: begin
                if (timer == '0) begin
                    state_nx = ST_HOLDOFF;
                    timer_nx = HOLD_LD;
                end else begin
                    timer_nx = timer - T_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (timer == '0) begin
                    state_nx = ST_WAIT_READY;
                    timer_nx = TOUT_LD;
                end else begin
                    timer_nx = timer - T_ONE;
                end
            end
            ST_WAIT_READY: begin
                // Ready takes priority over a coincident timeout.
                if (bus.ready) begin
                    state_nx = ST_ARMED;
                    timer_nx = '0;
                end else if (timer == '0) begin
                    if (retry_cnt < RETRY_MAX) begin
                        state_nx     = ST_ASSERT;
                        timer_nx     = RESET_LD;
                        retry_cnt_nx = retry_cnt + R_ONE;
                    end else begin
                        state_nx = ST_FAIL;
                        timer_nx = '0;
                    end
                end else begin
                    timer_nx = timer - T_ONE;
                end
            end
            ST_FAIL: begin
                state_nx = ST_FAIL;
            end
            default: begin
                state_nx = ST_IDLE;
                timer_nx = '0;
            end
        endcase

        enable_nx    = (state_nx == ST_ARMED);
        sys_reset_nx = (state_nx == ST_ASSERT) || (state_nx == ST_FAIL);
        fail_nx      = (state_nx == ST_FAIL);
        busy_nx      = (state_nx == ST_ASSERT) || (state_nx == ST_HOLDOFF) ||
                       (state_nx == ST_WAIT_READY) || (state_nx == ST_FAIL);
    end

    // State, timer, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            timer       <= '0;
            rec_cnt     <= '0;
            retry_cnt   <= '0;
            enable_q    <= 1'b0;
            sys_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            rec_cnt     <= rec_cnt_nx;
            retry_cnt   <= retry_cnt_nx;
            enable_q    <= enable_nx;
            sys_reset_q <= sys_reset_nx;
            busy_q      <= busy_nx;
            fail_q      <= fail_nx;
        end
    end

    assign bus.enable         = enable_q;
    assign bus.sys_reset      = sys_reset_q;
    assign bus.busy           = busy_q;
    assign bus.fail           = fail_q;
    assign bus.recovery_count = rec_cnt;
    assign bus.retry_count    = retry_cnt;

endmodule

// File: tb/tb_reset_recovery_ctrl.sv
// Bench for reset_recovery_ctrl: two instances (8-bit and 2-bit recovery
// counters) share one stimulus stream. A timestamp-based reference model
// predicts every output each cycle; directed steps add fixed-value checks.
module tb_reset_recovery_ctrl;

    localparam int ARM = 4;
    localparam int RC  = 8;
    localparam int HO  = 16;
    localparam int TO  = 255;
    localparam int MR  = 3;

    logic CLK = 1'b0;
    logic RST;
    logic det;
    logic rdy;

    int checks = 0;
    int errors = 0;

    // reference model state: edges since release, start edge of the current attempt
    int m_edge, m_start, m_rec, m_retry;
    bit m_armed, m_ep, m_fail;

    always #5 CLK = ~CLK;

    reset_recovery_ctrl_if #(.CNT_WIDTH(8), .RETRY_W(2)) bus ();
    reset_recovery_ctrl_if #(.CNT_WIDTH(2), .RETRY_W(2)) bus2 ();

    assign bus.detected  = det;
    assign bus.ready     = rdy;
    assign bus2.detected = det;
    assign bus2.ready    = rdy;

    reset_recovery_ctrl #(
        .ARM_CYCLES(ARM), .RESET_CYCLES(RC), .HOLDOFF_CYCLES(HO),
        .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .CNT_WIDTH(8)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    reset_recovery_ctrl #(
        .ARM_CYCLES(ARM), .RESET_CYCLES(RC), .HOLDOFF_CYCLES(HO),
        .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR), .CNT_WIDTH(2)
    ) dut2 (
        .CLK(CLK), .RST(RST), .bus(bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        int d;
        if (RST) begin
            m_edge = 0; m_start = 0; m_rec = 0; m_retry = 0;
            m_armed = 0; m_ep = 0; m_fail = 0;
        end else begin
            d = m_edge - m_start;
            m_edge++;
            if (m_fail) begin
                m_fail = 1;
            end else if (m_ep) begin
                if (d >= RC + HO) begin
                    if (rdy) begin
                        m_ep = 0;
                        m_armed = 1;
                    end else if (d == RC + HO + TO - 1) begin
                        if (m_retry < MR) begin
                            m_retry++;
                            m_start = m_edge;
                        end else begin
                            m_fail = 1;
                            m_ep = 0;
                        end
                    end
                end
            end else if (m_armed) begin
                if (det) begin
                    m_armed = 0;
                    m_ep = 1;
                    m_start = m_edge;
                    m_rec++;
                    m_retry = 0;
                end
            end else if (m_edge == ARM) begin
                m_armed = 1;
            end
        end
    endtask

    task automatic check_all();
        int d_now, e_en, e_sr, e_busy, e_fail, e_rec8, e_rec2;
        d_now  = m_edge - m_start;
        e_en   = m_armed ? 1 : 0;
        e_sr   = (m_fail || (m_ep && d_now < RC)) ? 1 : 0;
        e_busy = (m_fail || m_ep) ? 1 : 0;
        e_fail = m_fail ? 1 : 0;
        e_rec8 = (m_rec > 255) ? 255 : m_rec;
        e_rec2 = (m_rec > 3) ? 3 : m_rec;
        chk("enable",     32'(bus.enable),          e_en);
        chk("sys_reset",  32'(bus.sys_reset),       e_sr);
        chk("busy",       32'(bus.busy),            e_busy);
        chk("fail",       32'(bus.fail),            e_fail);
        chk("rec_count",  32'(bus.recovery_count),  e_rec8);
        chk("retry",      32'(bus.retry_count),     m_retry);
        chk("enable2",    32'(bus2.enable),         e_en);
        chk("sys_reset2", 32'(bus2.sys_reset),      e_sr);
        chk("busy2",      32'(bus2.busy),           e_busy);
        chk("fail2",      32'(bus2.fail),           e_fail);
        chk("rec_count2", 32'(bus2.recovery_count), e_rec2);
        chk("retry2",     32'(bus2.retry_count),    m_retry);
    endtask

    task automatic step(input logic d, input logic r);
        det = d;
        rdy = r;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) step(1'b0, 1'b0);
        RST = 1'b0;
    endtask

    initial begin
        int n0, pulses, run, maxr;
        logic prev;
        RST = 1'b1;
        det = 1'b0;
        rdy = 1'b0;

        // Reset values
        do_reset(3);
        chk("rst_enable", 32'(bus.enable), 0);
        chk("rst_sys_reset", 32'(bus.sys_reset), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_fail", 32'(bus.fail), 0);
        chk("rst_rec", 32'(bus.recovery_count), 0);
        chk("rst_retry", 32'(bus.retry_count), 0);

        // Arm delay, single recovery with late / hold-off pulses, ready from edge 30
        for (int e = 1; e <= 35; e++) begin
            step((e == 10) || (e == 11) || (e == 13) || (e == 20), (e >= 30));
            if (e == 3)  chk("arm_e3_enable", 32'(bus.enable), 0);
            if (e == 4)  chk("arm_e4_enable", 32'(bus.enable), 1);
            if (e == 4)  chk("arm_e4_busy", 32'(bus.busy), 0);
            if (e == 10) chk("det_e10_sys_reset", 32'(bus.sys_reset), 1);
            if (e == 10) chk("det_e10_enable", 32'(bus.enable), 0);
            if (e == 10) chk("det_e10_rec", 32'(bus.recovery_count), 1);
            if (e == 17) chk("det_e17_sys_reset", 32'(bus.sys_reset), 1);
            if (e == 18) chk("det_e18_sys_reset", 32'(bus.sys_reset), 0);
            if (e == 34) chk("rdy_e34_enable", 32'(bus.enable), 0);
            if (e == 35) chk("rdy_e35_enable", 32'(bus.enable), 1);
            if (e == 35) chk("late_rec", 32'(bus.recovery_count), 1);
        end
        step(1'b0, 1'b0);

        // Retry exhaustion: four pulses of RC cycles, then sticky fail
        step(1'b1, 1'b0);
        pulses = 1; run = 1; maxr = 0; prev = bus.sys_reset;
        for (int i = 0; i < 2000 && !bus.fail; i++) begin
            step(1'b0, 1'b0);
            if (bus.sys_reset && !prev && !bus.fail) begin
                pulses++;
                run = 0;
            end
            if (bus.sys_reset && !bus.fail) run++;
            else if (prev && !bus.fail) chk("pulse_width", run, RC);
            prev = bus.sys_reset;
            if (int'(bus.retry_count) > maxr) maxr = int'(bus.retry_count);
        end
        chk("fail_reached", 32'(bus.fail), 1);
        chk("pulse_count", pulses, 4);
        chk("retry_max", maxr, MR);
        repeat (5) step(1'b1, 1'b1);
        chk("fail_sticky", 32'(bus.fail), 1);
        chk("fail_sys_reset", 32'(bus.sys_reset), 1);
        do_reset(1);
        chk("clr_fail", 32'(bus.fail), 0);
        chk("clr_sys_reset", 32'(bus.sys_reset), 0);
        chk("clr_rec", 32'(bus.recovery_count), 0);

        // Ready exactly on the timeout-expiry edge
        repeat (ARM) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        n0 = m_edge;
        while (m_edge < n0 + RC + HO + TO - 1) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("tout_rdy_enable", 32'(bus.enable), 1);
        chk("tout_rdy_retry", 32'(bus.retry_count), 0);
        chk("tout_rdy_sys_reset", 32'(bus.sys_reset), 0);
        step(1'b0, 1'b0);
        chk("tout_rdy_no_pulse", 32'(bus.sys_reset), 0);

        // Five quick recoveries: the 2-bit counter saturates
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0);
            repeat (RC + HO) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
            step(1'b0, 1'b0);
        end
        chk("sat_rec2", 32'(bus2.recovery_count), 3);
        chk("sat_rec8", 32'(bus.recovery_count), 6);

        // RST in the middle of a pulse
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        chk("mid_sys_reset_before", 32'(bus.sys_reset), 1);
        RST = 1'b1;
        step(1'b0, 1'b0);
        RST = 1'b0;
        chk("mid_sys_reset", 32'(bus.sys_reset), 0);
        chk("mid_rec", 32'(bus.recovery_count), 0);
        chk("mid_rec2", 32'(bus2.recovery_count), 0);
        chk("mid_retry", 32'(bus.retry_count), 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            RST = ($urandom_range(0, 1499) == 0);
            step(($urandom_range(0, 7) == 0), ($urandom_range(0, 47) == 0));
        end
        RST = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
